// File: rtl/vertex_read_arbiter.sv
// Per-bank round-robin arbiter between eight vertex-read ports and a banked vertex buffer.
// Grants are combinational; responses return through a two-stage pipeline at fixed latency.
module vertex_read_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 16,
    parameter int Bank_Num_W = 5
) (
    input  logic                                            clk,
    input  logic                                            rst,
    input  logic [7:0]                                      req_valid,
    input  logic [8*ADDR_W-1:0]                             req_addr,
    output logic [7:0]                                      req_ready,
    output logic [7:0]                                      resp_valid,
    output logic [8*DATA_W-1:0]                             resp_data,
    output logic [(2**Bank_Num_W)-1:0]                      bank_ren,
    output logic [(2**Bank_Num_W)*(ADDR_W-Bank_Num_W)-1:0]  bank_raddr,
    input  logic [(2**Bank_Num_W)*DATA_W-1:0]               bank_rdata
);
    localparam int Bank_Num = 2**Bank_Num_W;
    localparam int RW       = ADDR_W - Bank_Num_W;
    localparam int NP       = 8;

    logic [NP-1:0]         live_valid;
    logic [Bank_Num_W-1:0] port_bank [NP];
    logic [RW-1:0]         port_row  [NP];
    logic [Bank_Num-1:0]   win_valid;
    logic [Bank_Num*3-1:0] win_idx;

    // Masking requests while in reset keeps req_ready and bank_ren low immediately.
    assign live_valid = req_valid & {NP{~rst}};

    always_comb begin
        for (int i = 0; i < NP; i++) begin
            port_bank[i] = req_addr[i*ADDR_W +: Bank_Num_W];
            port_row[i]  = req_addr[i*ADDR_W + Bank_Num_W +: RW];
        end
    end

    for (genvar gi = 0; gi < Bank_Num; gi++) begin : g_bank
        logic [2:0]    ptr_reg;
        logic [NP-1:0] cand;
        logic          found;
        logic [2:0]    sel;

        always_comb begin
            cand = '0;
            for (int i = 0; i < NP; i++)
                cand[i] = live_valid[i] && (port_bank[i] == Bank_Num_W'(gi));
        end

        // First candidate at or after the pointer, wrapping modulo 8.
        always_comb begin
            found = 1'b0;
            sel   = ptr_reg;
            for (int k = 0; k < NP; k++) begin
                if (!found && cand[ptr_reg + 3'(k)]) begin
                    found = 1'b1;
                    sel   = ptr_reg + 3'(k);
                end
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                ptr_reg <= '0;
            else if (found)
                ptr_reg <= sel + 3'd1;
        end

        assign win_valid[gi]          = found;
        assign win_idx[gi*3 +: 3]     = sel;
        assign bank_ren[gi]           = found;
        assign bank_raddr[gi*RW +: RW] = found ? port_row[sel] : '0;
    end

    always_comb begin
        req_ready = '0;
        for (int i = 0; i < NP; i++)
            req_ready[i] = win_valid[port_bank[i]] &&
                           (win_idx[port_bank[i]*3 +: 3] == 3'(i));
    end

    for (genvar gi = 0; gi < NP; gi++) begin : g_port
        logic                  s1_valid_reg;
        logic [Bank_Num_W-1:0] s1_bank_reg;
        logic                  resp_valid_reg;
        logic [DATA_W-1:0]     resp_data_reg;

        // Bank data arrives one cycle after the grant, so the bank index rides along in stage 1.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s1_valid_reg   <= 1'b0;
                s1_bank_reg    <= '0;
                resp_valid_reg <= 1'b0;
                resp_data_reg  <= '0;
            end else begin
                s1_valid_reg   <= req_valid[gi] && req_ready[gi];
                s1_bank_reg    <= port_bank[gi];
                resp_valid_reg <= s1_valid_reg;
                if (s1_valid_reg)
                    resp_data_reg <= bank_rdata[s1_bank_reg*DATA_W +: DATA_W];
            end
        end

        assign resp_valid[gi]                 = resp_valid_reg;
        assign resp_data[gi*DATA_W +: DATA_W] = resp_data_reg;
    end

endmodule

// File: tb/tb_vertex_read_arbiter.sv
// Directed bench for vertex_read_arbiter with a registered-read bank memory model.
// Inputs change 1 time unit after a rising edge; outputs are sampled 3 units after it.
module tb_vertex_read_arbiter;
    localparam int DW = 32;
    localparam int AW = 16;
    localparam int BW = 5;
    localparam int NB = 32;
    localparam int RW = 11;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic [7:0]         req_valid;
    logic [8*AW-1:0]    req_addr;
    logic [7:0]         req_ready;
    logic [7:0]         resp_valid;
    logic [8*DW-1:0]    resp_data;
    logic [NB-1:0]      bank_ren;
    logic [NB*RW-1:0]   bank_raddr;
    logic [NB*DW-1:0]   bank_rdata;

    int total = 0;
    int bad   = 0;

    vertex_read_arbiter #(.DATA_W(DW), .ADDR_W(AW), .Bank_Num_W(BW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .bank_ren   (bank_ren),
        .bank_raddr (bank_raddr),
        .bank_rdata (bank_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] bank_word(input int b, input int row);
        return 32'hB0 + 32'(b) + (32'(row) << 16);
    endfunction

    always @(posedge clk) begin
        for (int b = 0; b < NB; b++)
            if (bank_ren[b])
                bank_rdata[b*DW +: DW] <= bank_word(b, int'(bank_raddr[b*RW +: RW]));
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int p, input logic [15:0] a);
        req_addr[p*AW +: AW] = a;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        req_valid = '0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        req_valid = 8'hFF;
        for (int i = 0; i < 8; i++) set_addr(i, 16'(i));
        #3;
        total++; if (req_ready !== 8'h00) begin bad++; $display("FAIL rst_ready: got %h want 00", req_ready); end
        total++; if (bank_ren !== '0) begin bad++; $display("FAIL rst_ren: got %h want 0", bank_ren); end
        total++; if (resp_valid !== 8'h00) begin bad++; $display("FAIL rst_resp_valid: got %h want 00", resp_valid); end
        total++; if (resp_data !== '0) begin bad++; $display("FAIL rst_resp_data: got %h want 0", resp_data); end
        step();
        #2;
        total++; if (req_ready !== 8'h00) begin bad++; $display("FAIL rst_ready_clk: got %h want 00", req_ready); end
        total++; if (resp_valid !== 8'h00) begin bad++; $display("FAIL rst_resp_valid_clk: got %h want 00", resp_valid); end
        step();
        rst = 1'b0;
        req_valid = 8'h10;
        #2;
        total++; if (req_ready !== 8'h10) begin bad++; $display("FAIL rst_first_ready: got %h want 10", req_ready); end
        total++; if (bank_ren !== 32'h10) begin bad++; $display("FAIL rst_first_ren: got %h want 10", bank_ren); end
        step();
        req_valid = '0;
        #2;
        total++; if (resp_valid !== 8'h00) begin bad++; $display("FAIL rst_first_t1: got %h want 00", resp_valid); end
        step();
        #2;
        total++; if (resp_valid !== 8'h10) begin bad++; $display("FAIL rst_first_t2: got %h want 10", resp_valid); end
        total++; if (resp_data[4*DW +: DW] !== 32'hB4) begin bad++; $display("FAIL rst_first_data: got %h want 000000b4", resp_data[4*DW +: DW]); end
        step();
        #2;
        total++; if (resp_valid !== 8'h00) begin bad++; $display("FAIL rst_first_t3: got %h want 00", resp_valid); end
        $display("test_reset done");
    endtask

    task automatic test_no_conflict;
        do_reset();
        for (int i = 0; i < 8; i++) set_addr(i, 16'(i));
        req_valid = 8'hFF;
        #2;
        total++; if (req_ready !== 8'hFF) begin bad++; $display("FAIL nc_ready: got %h want ff", req_ready); end
        total++; if (bank_ren !== 32'hFF) begin bad++; $display("FAIL nc_ren: got %h want ff", bank_ren); end
        total++; if (bank_raddr !== '0) begin bad++; $display("FAIL nc_raddr: got %h want 0", bank_raddr); end
        step();
        req_valid = '0;
        #2;
        total++; if (resp_valid !== 8'h00) begin bad++; $display("FAIL nc_t1: got %h want 00", resp_valid); end
        step();
        #2;
        total++; if (resp_valid !== 8'hFF) begin bad++; $display("FAIL nc_t2: got %h want ff", resp_valid); end
        for (int i = 0; i < 8; i++) begin
            total++;
            if (resp_data[i*DW +: DW] !== bank_word(i, 0)) begin
                bad++; $display("FAIL nc_data port=%0d: got %h want %h", i, resp_data[i*DW +: DW], bank_word(i, 0));
            end
        end
        step();
        $display("test_no_conflict done");
    endtask

    task automatic test_full_conflict;
        logic [7:0] exp_rdy;
        logic [7:0] exp_rv;
        do_reset();
        for (int i = 0; i < 8; i++) set_addr(i, 16'((i << 5) | 3));
        req_valid = 8'hFF;
        for (int c = 0; c < 11; c++) begin
            #2;
            exp_rdy = (c < 8) ? 8'(1 << c) : 8'h00;
            exp_rv  = (c >= 2 && c < 10) ? 8'(1 << (c - 2)) : 8'h00;
            total++; if (req_ready !== exp_rdy) begin bad++; $display("FAIL fc_ready c=%0d: got %h want %h", c, req_ready, exp_rdy); end
            if (c < 8) begin
                total++; if (bank_raddr[3*RW +: RW] !== RW'(c)) begin bad++; $display("FAIL fc_raddr c=%0d: got %h want %h", c, bank_raddr[3*RW +: RW], RW'(c)); end
            end
            total++; if (resp_valid !== exp_rv) begin bad++; $display("FAIL fc_resp_valid c=%0d: got %h want %h", c, resp_valid, exp_rv); end
            if (c >= 2 && c < 10) begin
                total++;
                if (resp_data[(c-2)*DW +: DW] !== bank_word(3, c - 2)) begin
                    bad++; $display("FAIL fc_data c=%0d: got %h want %h", c, resp_data[(c-2)*DW +: DW], bank_word(3, c - 2));
                end
            end
            step();
            if (c < 8) req_valid[c] = 1'b0;
        end
        // Pointer must have wrapped back to 0: port 0 beats port 7.
        set_addr(0, 16'h0003);
        set_addr(7, 16'h0003);
        req_valid = 8'h81;
        #2;
        total++; if (req_ready !== 8'h01) begin bad++; $display("FAIL fc_ptr_wrap: got %h want 01", req_ready); end
        step();
        req_valid = '0;
        step();
        step();
        $display("test_full_conflict done");
    endtask

    task automatic test_fairness;
        int seq [4] = '{2, 6, 2, 6};
        logic [7:0] exp_rdy;
        logic [7:0] exp_rv;
        int p;
        do_reset();
        set_addr(2, 16'h0020);
        set_addr(6, 16'h0040);
        req_valid = 8'h44;
        for (int c = 0; c < 6; c++) begin
            #2;
            exp_rdy = (c < 4) ? 8'(1 << seq[c]) : 8'h00;
            exp_rv  = (c >= 2) ? 8'(1 << seq[c-2]) : 8'h00;
            total++; if (req_ready !== exp_rdy) begin bad++; $display("FAIL fair_ready c=%0d: got %h want %h", c, req_ready, exp_rdy); end
            total++; if (resp_valid !== exp_rv) begin bad++; $display("FAIL fair_resp_valid c=%0d: got %h want %h", c, resp_valid, exp_rv); end
            if (c >= 2) begin
                p = seq[c-2];
                total++;
                if (resp_data[p*DW +: DW] !== bank_word(0, (p == 2) ? 1 : 2)) begin
                    bad++; $display("FAIL fair_data c=%0d: got %h want %h", c, resp_data[p*DW +: DW], bank_word(0, (p == 2) ? 1 : 2));
                end
            end
            step();
            if (c == 3) req_valid = '0;
        end
        $display("test_fairness done");
    endtask

    task automatic test_back_to_back;
        logic [7:0] exp_rdy;
        logic [7:0] exp_rv;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            if (c < 3) begin
                set_addr(5, 16'h0021 + 16'(c) * 16'h0020);
                req_valid = 8'h20;
            end else begin
                req_valid = '0;
            end
            #2;
            exp_rdy = (c < 3) ? 8'h20 : 8'h00;
            exp_rv  = (c >= 2 && c < 5) ? 8'h20 : 8'h00;
            total++; if (req_ready !== exp_rdy) begin bad++; $display("FAIL b2b_ready c=%0d: got %h want %h", c, req_ready, exp_rdy); end
            if (c < 3) begin
                total++; if (bank_raddr[1*RW +: RW] !== RW'(c + 1)) begin bad++; $display("FAIL b2b_raddr c=%0d: got %h want %h", c, bank_raddr[1*RW +: RW], RW'(c + 1)); end
            end
            total++; if (resp_valid !== exp_rv) begin bad++; $display("FAIL b2b_resp_valid c=%0d: got %h want %h", c, resp_valid, exp_rv); end
            if (c >= 2 && c < 5) begin
                total++;
                if (resp_data[5*DW +: DW] !== bank_word(1, c - 1)) begin
                    bad++; $display("FAIL b2b_data c=%0d: got %h want %h", c, resp_data[5*DW +: DW], bank_word(1, c - 1));
                end
            end
            step();
        end
        $display("test_back_to_back done");
    endtask

    task automatic test_reset_midflight;
        do_reset();
        set_addr(0, 16'h0000);
        req_valid = 8'h01;
        #2;
        total++; if (req_ready !== 8'h01) begin bad++; $display("FAIL mid_ready: got %h want 01", req_ready); end
        step();
        req_valid = '0;
        rst = 1'b1;
        #2;
        total++; if (resp_valid !== 8'h00) begin bad++; $display("FAIL mid_t1: got %h want 00", resp_valid); end
        step();
        rst = 1'b0;
        #2;
        total++; if (resp_valid !== 8'h00) begin bad++; $display("FAIL mid_t2: got %h want 00", resp_valid); end
        step();
        #2;
        total++; if (resp_valid !== 8'h00) begin bad++; $display("FAIL mid_t3: got %h want 00", resp_valid); end
        step();
        set_addr(0, 16'h0020);
        req_valid = 8'h01;
        #2;
        total++; if (req_ready !== 8'h01) begin bad++; $display("FAIL mid_new_ready: got %h want 01", req_ready); end
        step();
        req_valid = '0;
        #2;
        total++; if (resp_valid !== 8'h00) begin bad++; $display("FAIL mid_new_t1: got %h want 00", resp_valid); end
        step();
        #2;
        total++; if (resp_valid !== 8'h01) begin bad++; $display("FAIL mid_new_t2: got %h want 01", resp_valid); end
        total++; if (resp_data[0 +: DW] !== bank_word(0, 1)) begin bad++; $display("FAIL mid_new_data: got %h want %h", resp_data[0 +: DW], bank_word(0, 1)); end
        step();
        $display("test_reset_midflight done");
    endtask

    initial begin
        req_valid = '0;
        req_addr  = '0;
        test_reset();
        test_no_conflict();
        test_full_conflict();
        test_fairness();
        test_back_to_back();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/vertex_read_arbiter.md
# vertex_read_arbiter

Bank-conflict arbiter and read sequencer that sits between the eight vertex-read ports of the processing pipelines and the banked vertex buffer. Each cycle it maps every pending read to its bank and grants at most one port per bank, using a per-bank round-robin. It drives the bank read addresses and returns each bank's data to the port that issued the read, with a fixed latency. Ports that are not granted are back-pressured through a valid/ready handshake.

## Interface
Parameters:
- DATA_W, 32, vertex word width
- ADDR_W, 16, full vertex address width
- Bank_Num_W, 5, log2 of bank count; Bank_Num = 2**Bank_Num_W; row width RW = ADDR_W-Bank_Num_W

Ports:
- clk  in  1  single clock; all logic is on the rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  8  per-port read request
- req_addr  in  8*ADDR_W  port i occupies [i*ADDR_W +: ADDR_W]
- req_ready  out  8  per-port grant; combinational
- resp_valid  out  8  registered; read data valid
- resp_data  out  8*DATA_W  registered; port i occupies [i*DATA_W +: DATA_W]
- bank_ren  out  Bank_Num  combinational; bank read enable
- bank_raddr  out  Bank_Num*RW  combinational; bank b occupies [b*RW +: RW]
- bank_rdata  in  Bank_Num*DATA_W  bank read data, valid one cycle after bank_ren

## Operation
- Address split:
  - bank = req_addr[Bank_Num_W-1:0]
  - row = req_addr[ADDR_W-1:Bank_Num_W]
- Per-bank arbitration:
  - Each bank b holds a 3-bit round-robin pointer ptr[b]; reset value is 0.
  - Candidates for bank b are the ports i with req_valid[i] and bank(i)==b.
  - The winner is the first candidate found searching i = ptr[b], ptr[b]+1, … mod 8.
  - On a grant, ptr[b] <= winner+1 (mod 8). With no candidates, ptr[b] holds.
- For each port, req_ready[i] = 1 only if port i is the winner of its own bank. A port requests only one bank, so it is granted at most once per cycle.
- Transfer rule: a read is accepted when req_valid & req_ready are both high. Requesters hold addr and valid stable until they are accepted.
- Bank drive for each bank with a winner:
  - bank_ren[b] = 1
  - bank_raddr[b] = row of the winner
- Bank drive for each bank with no winner:
  - bank_ren[b] = 0
  - bank_raddr[b] = 0
- Stage-1 registers are kept per port:
  - s1_valid[i] <= accepted[i]
  - s1_bank[i] <= bank(i)
- Stage-2 output:
  - resp_valid[i] <= s1_valid[i]
  - resp_data[i] <= bank_rdata[s1_bank[i]] when s1_valid[i] is set; otherwise resp_data[i] holds its value.
- Every response is delivered in order per port. There is no response back-pressure.
- Fully pipelined: a port can be accepted every cycle when it is uncontended.

## Timing
- Latency: accept in cycle T, bank read in T+1, resp_valid[i]=1 in cycle T+2 for exactly one cycle per accepted read.
- Throughput:
  - Up to min(8, Bank_Num) reads per cycle.
  - N ports contending for one bank complete in N consecutive cycles.
- req_ready and the bank outputs depend combinationally on req_valid, req_addr and ptr. req_ready does not depend on resp_*.
- Simultaneous events:
  - Ports that hit distinct banks are all granted in the same cycle.
  - Two ports reading the same address contend like any other same-bank pair.
- Wrap-around:
  - The pointer wraps from 7 to 0.
  - A winner of 7 sets ptr to 0.
- Reset values, applied asynchronously and effective immediately:
  - all ptr = 0
  - s1_valid = 0, s1_bank = 0
  - resp_valid = 0, resp_data = 0
- Reset mid-operation:
  - In-flight reads are discarded and no resp_valid is produced for them.
  - While rst is high, req_ready = 0 and bank_ren = 0.
  - After rst falls, the first accepted read responds at T+2.

## Test plan
- Reset check: assert rst, then release it.
  - During reset, all resp_valid, req_ready and bank_ren = 0, and resp_data = 0.
  - A single request issued afterwards is granted in the same cycle.
- No conflict: all 8 ports valid with addresses 0x0000..0x0007 (banks 0..7), with bank b returning data 0xB0+b.
  - All req_ready = 1 in cycle T.
  - bank_raddr = 0 for all eight banks.
  - In T+2, all 8 resp_valid = 1 and resp_data[i] = 0xB0+i.
- Full conflict: all 8 ports request bank 3 and are held.
  - Grants go to ports 0,1,…,7 in consecutive cycles, one per cycle.
  - ptr[3] ends at 0.
  - Each port sees resp_valid exactly once, 2 cycles after its grant.
- Fairness after wrap: ports 2 and 6 continuously request bank 0 with ptr[0]=0 initially.
  - Grants alternate 2,6,2,6. Neither port is starved for more than 1 cycle.
- Back-to-back streaming: port 5 issues 0x0021,0x0041,0x0061 in consecutive cycles with no contention.
  - req_ready stays 1 throughout.
  - bank_raddr[1] = 1,2,3 in those cycles.
  - resp_valid[5] is high for 3 consecutive cycles, carrying the data in order.
- Reset mid-flight: accept a read on port 0 in cycle T and assert rst in T+1.
  - No resp_valid[0] pulse occurs.
  - After rst deasserts, a new read on port 0 completes normally at +2 cycles.
